// File: rtl/fp_cvt_pkg.sv
// Shared constants and types for the floating-point conversion stages.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package fp_cvt_pkg;

  // Rounding-mode encodings; RM_DYN selects the dynamic mode from fcsr
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // Double bias (1023) minus single bias (127)
  localparam logic [10:0] BIAS_DELTA = 11'd896;

  typedef enum logic [2:0] {
    CLS_NUM,
    CLS_ZERO,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN,
    CLS_ILL
  } cls_e;

  // Unpacked operand carried from S1 to S2. exp is the biased single
  // exponent before rounding (0 for subnormal results, 255 when the operand
  // already overflows). bord/ug/ur/us describe the e==0 case re-rounded at
  // normal precision, used only for tininess-after-rounding.
  typedef struct packed {
    logic        sign;
    cls_e        cls;
    logic [2:0]  rm;
    logic [8:0]  exp;
    logic [22:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic        bord;
    logic        ug;
    logic        ur;
    logic        us;
  } s1_t;

  // Overflow result for the given sign and rounding mode
  function automatic logic [31:0] ovf_result(input logic sign, input logic [2:0] rm);
    logic [31:0] inf_v;
    logic [31:0] max_v;
    logic [31:0] res;
    inf_v = {sign, 8'hFF, 23'd0};
    max_v = {sign, 8'hFE, 23'h7FFFFF};
    case (rm)
      RM_RTZ:  res = max_v;
      RM_RDN:  res = sign ? inf_v : max_v;
      RM_RUP:  res = sign ? max_v : inf_v;
      default: res = inf_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fp_round_s.sv
// Single-precision round decision and increment on a {exp, mantissa} pair.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fp_round_s
  import fp_cvt_pkg::*;
(
  input  logic        sign,
  input  logic [2:0]  rm,
  input  logic [8:0]  exp_in,
  input  logic [22:0] mant_in,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  output logic [8:0]  exp_out,
  output logic [22:0] mant_out,
  output logic        nx
);

  logic        inc;
  logic [31:0] sum;

  // Round-up decision for the selected mode (L is the mantissa lsb)
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (r | s | mant_in[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
  end

  // Adding on the packed {exp,mant} lets a mantissa carry bump the exponent,
  // which also turns a subnormal rounding up to 2^-126 into exponent field 1.
  assign sum      = {exp_in, mant_in} + {31'd0, inc};
  assign exp_out  = sum[31:23];
  assign mant_out = sum[22:0];
  assign nx       = g | r | s;

endmodule

// File: rtl/fp_cvt_ds_pipe.sv
// Double to single conversion, NaN-boxed result, IEEE flags.
// Latency: 2 cycles (S1 unpack/align, S2 round/pack), throughput 1 per cycle.
// Backpressure: valid/ready per stage; S2 holds its result while out_ready=0.
module fp_cvt_ds_pipe
  import fp_cvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_d,
  input  logic [2:0]  in_rm,
  input  logic [2:0]  frm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_s,
  output logic [4:0]  out_flags,
  output logic        out_illegal
);

  localparam logic [10:0] EXP_OVF = BIAS_DELTA + 11'd255; // e >= 255
  localparam logic [10:0] EXP_FAR = BIAS_DELTA - 11'd25;  // shift >= 26

  logic        s1_valid_q, s1_valid_d;
  s1_t         s1_q, s1_d, s1_new;
  logic        s2_valid_q, s2_valid_d;
  logic [63:0] out_s_q, out_s_d;
  logic [4:0]  out_flags_q, out_flags_d;
  logic        out_illegal_q, out_illegal_d;
  logic        s2_advance;

  logic        in_sign;
  logic [10:0] exp_d;
  logic [51:0] frac_d;
  logic [2:0]  rm_eff;
  logic [10:0] e_raw;
  logic [10:0] sh_raw;
  logic [104:0] ext;

  logic [8:0]  rnd_exp, unb_exp;
  logic [22:0] rnd_mant, unb_mant;
  logic        rnd_nx, unb_nx;
  logic [31:0] res_s;
  logic [4:0]  res_fl;
  logic        res_ill;
  logic        unused_bits;

  assign s2_advance = ~s2_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_advance;

  assign in_sign = in_d[63];
  assign exp_d   = in_d[62:52];
  assign frac_d  = in_d[51:0];
  assign rm_eff  = (in_rm == RM_DYN) ? frm : in_rm;
  assign e_raw   = exp_d - BIAS_DELTA;
  assign sh_raw  = BIAS_DELTA + 11'd1 - exp_d;
  // Shifted-out bits land in the low zero pad and are folded into sticky
  assign ext     = {1'b1, frac_d, 52'd0} >> sh_raw[4:0];

  // S1: classify and align the operand to 24 bits plus guard/round/sticky
  always_comb begin
    s1_new      = '0;
    s1_new.sign = in_sign;
    s1_new.rm   = rm_eff;
    s1_new.cls  = CLS_NUM;
    if (rm_eff > RM_RMM) begin
      s1_new.cls = CLS_ILL;
    end else if (exp_d == 11'h7FF) begin
      s1_new.cls = (frac_d == '0) ? CLS_INF : (frac_d[51] ? CLS_QNAN : CLS_SNAN);
    end else if (exp_d == 11'd0 && frac_d == '0) begin
      s1_new.cls = CLS_ZERO;
    end else if (exp_d >= EXP_OVF) begin
      s1_new.exp = 9'd255;
    end else if (exp_d > BIAS_DELTA) begin
      s1_new.exp  = e_raw[8:0];
      s1_new.mant = frac_d[51:29];
      s1_new.g    = frac_d[28];
      s1_new.r    = frac_d[27];
      s1_new.s    = |frac_d[26:0];
    end else if (exp_d <= EXP_FAR) begin
      s1_new.s = 1'b1;
    end else begin
      s1_new.mant = ext[103:81];
      s1_new.g    = ext[80];
      s1_new.r    = ext[79];
      s1_new.s    = |ext[78:0];
      s1_new.bord = (exp_d == BIAS_DELTA) & (&frac_d[51:29]);
      s1_new.ug   = frac_d[28];
      s1_new.ur   = frac_d[27];
      s1_new.us   = |frac_d[26:0];
    end
  end

  fp_round_s u_round (
    .sign     (s1_q.sign),
    .rm       (s1_q.rm),
    .exp_in   (s1_q.exp),
    .mant_in  (s1_q.mant),
    .g        (s1_q.g),
    .r        (s1_q.r),
    .s        (s1_q.s),
    .exp_out  (rnd_exp),
    .mant_out (rnd_mant),
    .nx       (rnd_nx)
  );

  // Same rounding at full 24-bit precision for an all-ones e==0 operand;
  // a carry here means the unbounded-exponent result reaches 2^-126.
  fp_round_s u_tiny (
    .sign     (s1_q.sign),
    .rm       (s1_q.rm),
    .exp_in   (9'd0),
    .mant_in  (23'h7FFFFF),
    .g        (s1_q.ug),
    .r        (s1_q.ur),
    .s        (s1_q.us),
    .exp_out  (unb_exp),
    .mant_out (unb_mant),
    .nx       (unb_nx)
  );

  assign unused_bits = ^{e_raw[10:9], sh_raw[10:5], ext[104], unb_mant, unb_nx};

  // S2: select special result or rounded value, detect overflow/underflow
  always_comb begin
    res_s   = CANON_NAN;
    res_fl  = '0;
    res_ill = 1'b0;
    case (s1_q.cls)
      CLS_ILL:  res_ill = 1'b1;
      CLS_QNAN: res_fl  = '0;
      CLS_SNAN: res_fl[FLG_NV] = 1'b1;
      CLS_INF:  res_s = {s1_q.sign, 8'hFF, 23'd0};
      CLS_ZERO: res_s = {s1_q.sign, 31'd0};
      default: begin
        if (rnd_exp >= 9'd255) begin
          res_s          = ovf_result(s1_q.sign, s1_q.rm);
          res_fl[FLG_OF] = 1'b1;
          res_fl[FLG_NX] = 1'b1;
        end else begin
          res_s          = {s1_q.sign, rnd_exp[7:0], rnd_mant};
          res_fl[FLG_NX] = rnd_nx;
          res_fl[FLG_UF] = rnd_nx & (s1_q.exp == 9'd0) & ~(s1_q.bord & (unb_exp != 9'd0));
        end
      end
    endcase
    res_fl[FLG_DZ] = 1'b0;
  end

  // Handshake: load S1 on input transfer, move S1 into S2 when S2 can advance
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_d          = s1_q;
    s2_valid_d    = s2_valid_q;
    out_s_d       = out_s_q;
    out_flags_d   = out_flags_q;
    out_illegal_d = out_illegal_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = s1_new;
    end
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_s_d       = {32'hFFFF_FFFF, res_s};
        out_flags_d   = res_fl;
        out_illegal_d = res_ill;
      end
    end
  end

  // Pipeline registers; reset drops anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      s2_valid_q    <= 1'b0;
      out_s_q       <= '0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      s2_valid_q    <= s2_valid_d;
      out_s_q       <= out_s_d;
      out_flags_q   <= out_flags_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_s       = out_s_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_fp_cvt_ds_pipe.sv
// Scoreboard bench for fp_cvt_ds_pipe with directed vectors.
// Expected results are pushed on input handshake and popped by the monitor.
// Backpressure and reset-in-flight scenarios are exercised.
module tb_fp_cvt_ds_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_d;
  logic [2:0]  in_rm;
  logic [2:0]  frm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_s;
  logic [4:0]  out_flags;
  logic        out_illegal;

  typedef struct packed {
    logic [31:0] s;
    logic [4:0]  fl;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fp_cvt_ds_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_d        (in_d),
    .in_rm       (in_rm),
    .frm         (frm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_flags   (out_flags),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: compare any presented result with the head of the scoreboard;
  // while stalled the held value must still match the head.
  always @(negedge clk) begin
    string tag;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h with no result pending", out_s);
      end else begin
        tag = out_ready ? "result" : "held";
        chk({tag, "_s"}, out_s, {32'hFFFF_FFFF, sb[0].s});
        chk({tag, "_flags"}, {59'd0, out_flags}, {59'd0, sb[0].fl});
        chk({tag, "_illegal"}, {63'd0, out_illegal}, {63'd0, sb[0].ill});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [2:0] rm, input logic [2:0] f,
                      input logic [31:0] es, input logic [4:0] ef, input logic ei);
    bit done = 1'b0;
    in_d     = d;
    in_rm    = rm;
    frm      = f;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({es, ef, ei});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = '0;
    in_rm     = 3'b000;
    frm       = 3'b000;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_s", out_s, 64'd0);
    chk("rst_flags", {59'd0, out_flags}, 64'd0);
    chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Latency: result visible in the second cycle after the accepting edge
    send(64'h3FF0000000000000, 3'b000, 3'b000, 32'h3F800000, 5'h00, 1'b0);
    @(negedge clk);
    chk("latency_cycle1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_cycle2", {63'd0, out_valid}, 64'd1);
    idle(1);

    // Back-to-back directed vectors
    send(64'h3FF0000010000000, 3'b000, 3'b000, 32'h3F800000, 5'h01, 1'b0);
    send(64'h3FF0000010000000, 3'b011, 3'b000, 32'h3F800001, 5'h01, 1'b0);
    send(64'h3FF0000010000000, 3'b111, 3'b011, 32'h3F800001, 5'h01, 1'b0);
    send(64'h3FF0000000000000, 3'b111, 3'b111, 32'h7FC00000, 5'h00, 1'b1);
    send(64'h3FF0000000000000, 3'b101, 3'b000, 32'h7FC00000, 5'h00, 1'b1);
    send(64'h3FF0000000000000, 3'b110, 3'b000, 32'h7FC00000, 5'h00, 1'b1);
    send(64'h7FEFFFFFFFFFFFFF, 3'b000, 3'b000, 32'h7F800000, 5'h05, 1'b0);
    send(64'h7FEFFFFFFFFFFFFF, 3'b001, 3'b000, 32'h7F7FFFFF, 5'h05, 1'b0);
    send(64'h7FEFFFFFFFFFFFFF, 3'b010, 3'b000, 32'h7F7FFFFF, 5'h05, 1'b0);
    send(64'h7FEFFFFFFFFFFFFF, 3'b011, 3'b000, 32'h7F800000, 5'h05, 1'b0);
    send(64'hFFEFFFFFFFFFFFFF, 3'b010, 3'b000, 32'hFF800000, 5'h05, 1'b0);
    send(64'hFFEFFFFFFFFFFFFF, 3'b011, 3'b000, 32'hFF7FFFFF, 5'h05, 1'b0);
    send(64'hFFEFFFFFFFFFFFFF, 3'b100, 3'b000, 32'hFF800000, 5'h05, 1'b0);
    send(64'h7FF0000000000001, 3'b000, 3'b000, 32'h7FC00000, 5'h10, 1'b0);
    send(64'h7FF8000000000000, 3'b000, 3'b000, 32'h7FC00000, 5'h00, 1'b0);
    send(64'h7FF0000000000000, 3'b000, 3'b000, 32'h7F800000, 5'h00, 1'b0);
    send(64'hFFF0000000000000, 3'b001, 3'b000, 32'hFF800000, 5'h00, 1'b0);
    send(64'h8000000000000000, 3'b000, 3'b000, 32'h80000000, 5'h00, 1'b0);
    send(64'h0000000000000000, 3'b011, 3'b000, 32'h00000000, 5'h00, 1'b0);
    send(64'h3FFFFFFFF0000000, 3'b000, 3'b000, 32'h40000000, 5'h01, 1'b0);
    send(64'h3FFFFFFFF0000000, 3'b001, 3'b000, 32'h3FFFFFFF, 5'h01, 1'b0);
    send(64'h47EFFFFFF0000000, 3'b000, 3'b000, 32'h7F800000, 5'h05, 1'b0);
    send(64'h47EFFFFFF0000000, 3'b001, 3'b000, 32'h7F7FFFFF, 5'h01, 1'b0);
    send(64'h37D0000000000000, 3'b000, 3'b000, 32'h00080000, 5'h00, 1'b0);
    send(64'h36A0000000000000, 3'b000, 3'b000, 32'h00000001, 5'h00, 1'b0);
    send(64'h3690000000000000, 3'b000, 3'b000, 32'h00000000, 5'h03, 1'b0);
    send(64'h3690000000000000, 3'b011, 3'b000, 32'h00000001, 5'h03, 1'b0);
    send(64'h3690000000000000, 3'b100, 3'b000, 32'h00000001, 5'h03, 1'b0);
    send(64'h0000000000000001, 3'b000, 3'b000, 32'h00000000, 5'h03, 1'b0);
    send(64'h8000000000000001, 3'b010, 3'b000, 32'h80000001, 5'h03, 1'b0);
    send(64'h380FFFFFFFFFFFFF, 3'b000, 3'b000, 32'h00800000, 5'h01, 1'b0);
    send(64'h380FFFFFFFFFFFFF, 3'b001, 3'b000, 32'h007FFFFF, 5'h03, 1'b0);
    send(64'h380FFFFFE0000000, 3'b000, 3'b000, 32'h00800000, 5'h03, 1'b0);
    idle(5);

    // Backpressure: fill both stages, stall three cycles, then release
    out_ready = 1'b0;
    send(64'h3FF0000000000000, 3'b000, 3'b000, 32'h3F800000, 5'h00, 1'b0);
    send(64'h4000000000000000, 3'b000, 3'b000, 32'h40000000, 5'h00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_full", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(64'hC008000000000000, 3'b000, 3'b000, 32'hC0400000, 5'h00, 1'b0);
    idle(4);

    // Reset with two operands in flight
    out_ready = 1'b0;
    send(64'h3FF0000000000000, 3'b000, 3'b000, 32'h3F800000, 5'h00, 1'b0);
    send(64'h4000000000000000, 3'b000, 3'b000, 32'h40000000, 5'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_s", out_s, 64'd0);
    chk("midrst_flags", {59'd0, out_flags}, 64'd0);
    sb.delete();
    idle(2);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midrst", {63'd0, in_ready}, 64'd1);
    idle(6);
    send(64'hBFF0000000000000, 3'b000, 3'b000, 32'hBF800000, 5'h00, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
